// File: rtl/riscv_testutil_bus_arb.sv
// riscv_testutil_bus_arb
// Two-host (core, test-utility) to one-device data-memory arbiter. One request is
// granted per cycle; an in-order owner FIFO remembers who issued each accepted
// request so that every memory response is routed back to its issuer.
// Grant and response paths are purely combinational; only the owner FIFO, its
// pointers/counter, the last-winner bit and the sticky error flag are registered.
// Optional feature macro: RISCV_TESTUTIL_ARB_RR_EN
//   defined   -> round-robin arbitration on contention
//   undefined -> fixed priority, test-utility host always wins on contention
module riscv_testutil_bus_arb #(
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   // core data port
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic [3:0]  core_be_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wdata_i,
   output logic        core_gnt_o,
   output logic        core_rvalid_o,
   output logic [31:0] core_rdata_o,
   output logic        core_err_o,
   // test-utility read port
   input  logic        tu_req_i,
   input  logic [31:0] tu_addr_i,
   output logic        tu_gnt_o,
   output logic        tu_rvalid_o,
   output logic [31:0] tu_rdata_o,
   // memory device port
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_err_i,
   // sticky flag: response seen with no request outstanding
   output logic        unexpected_rvalid_o
);

   localparam int unsigned    CntW     = $clog2(MaxOutstanding) + 1;
   localparam int unsigned    PtrW     = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
   localparam logic [CntW-1:0] CntZero = {CntW{1'b0}};
   localparam logic [CntW-1:0] CntOne  = CntW'(1);
   localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);
   localparam logic [PtrW-1:0] PtrZero = {PtrW{1'b0}};
   localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
   localparam logic            OwnerTu = 1'b1;

   // Owner FIFO state: one bit per outstanding request, 0 = core, 1 = tu
   logic [MaxOutstanding-1:0] owner_q, owner_d;
   logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]           cnt_q, cnt_d;
   logic                      unexp_q, unexp_d;

   logic fifo_full_s;
   logic fifo_empty_s;
   logic head_s;
   logic tu_win_s;
   logic accept_s;
   logic pop_s;

   assign fifo_full_s  = (cnt_q == CntMax);
   assign fifo_empty_s = (cnt_q == CntZero);
   assign head_s       = owner_q[rd_ptr_q];
   assign accept_s     = mem_req_o & mem_gnt_i;
   // A response with nothing outstanding is flagged, never popped or forwarded
   assign pop_s        = mem_rvalid_i & ~fifo_empty_s;

`ifdef RISCV_TESTUTIL_ARB_RR_EN
   // Last accepted winner: 1 = tu, 0 = core
   logic last_tu_q, last_tu_d;

   // On contention, favour the host that did not win the last accepted request
   always_comb begin
      tu_win_s = tu_req_i & (~core_req_i | ~last_tu_q);
   end

   // Remember the winner only when the memory actually accepted the request
   always_comb begin
      if (accept_s) begin
         last_tu_d = tu_win_s;
      end else begin
         last_tu_d = last_tu_q;
      end
   end

   // Last-winner register; comes out of reset as tu so the core wins first
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_tu_q <= 1'b1;
      end else begin
         last_tu_q <= last_tu_d;
      end
   end
`else
   // Fixed priority: the signature dump (tu) can never be starved by the core
   always_comb begin
      tu_win_s = tu_req_i;
   end
`endif

   // Drive the memory request fields from the winning host
   always_comb begin
      mem_we_o    = 1'b0;
      mem_be_o    = 4'h0;
      mem_addr_o  = 32'h0;
      mem_wdata_o = 32'h0;
      if (tu_win_s) begin
         mem_we_o    = 1'b0;
         mem_be_o    = 4'hf;
         mem_addr_o  = tu_addr_i;
         mem_wdata_o = 32'h0;
      end else if (core_req_i) begin
         mem_we_o    = core_we_i;
         mem_be_o    = core_be_i;
         mem_addr_o  = core_addr_i;
         mem_wdata_o = core_wdata_i;
      end else begin
         mem_we_o    = 1'b0;
         mem_be_o    = 4'h0;
         mem_addr_o  = 32'h0;
         mem_wdata_o = 32'h0;
      end
      mem_req_o = (core_req_i | tu_req_i) & ~fifo_full_s;
   end

   // Return the grant to the winner only; the loser sees no grant
   always_comb begin
      core_gnt_o = accept_s & ~tu_win_s;
      tu_gnt_o   = accept_s & tu_win_s;
   end

   // Route each response to the host at the head of the owner FIFO
   always_comb begin
      core_rvalid_o = 1'b0;
      tu_rvalid_o   = 1'b0;
      if (pop_s) begin
         if (head_s == OwnerTu) begin
            tu_rvalid_o = 1'b1;
         end else begin
            core_rvalid_o = 1'b1;
         end
      end else begin
         core_rvalid_o = 1'b0;
         tu_rvalid_o   = 1'b0;
      end
   end

   // Read data fans out to both hosts; errors only reach the core
   always_comb begin
      core_rdata_o = mem_rdata_i;
      tu_rdata_o   = mem_rdata_i;
      core_err_o   = mem_err_i & core_rvalid_o;
   end

   assign unexpected_rvalid_o = unexp_q;

   // Next-state for owner storage, pointers, occupancy and the sticky flag
   always_comb begin
      owner_d  = owner_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (accept_s) begin
         owner_d[wr_ptr_q] = tu_win_s;
         wr_ptr_d          = (wr_ptr_q == PtrLast) ? PtrZero : (wr_ptr_q + PtrOne);
      end else begin
         owner_d  = owner_q;
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = (rd_ptr_q == PtrLast) ? PtrZero : (rd_ptr_q + PtrOne);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({accept_s, pop_s})
         2'b10:   cnt_d = cnt_q + CntOne;
         2'b01:   cnt_d = cnt_q - CntOne;
         default: cnt_d = cnt_q;
      endcase
      unexp_d = unexp_q | (mem_rvalid_i & fifo_empty_s);
   end

   // FIFO and flag registers; reset discards all owner information
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         owner_q  <= {MaxOutstanding{1'b0}};
         wr_ptr_q <= PtrZero;
         rd_ptr_q <= PtrZero;
         cnt_q    <= CntZero;
         unexp_q  <= 1'b0;
      end else begin
         owner_q  <= owner_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         unexp_q  <= unexp_d;
      end
   end

endmodule

// File: tb/tb_riscv_testutil_bus_arb.sv
// Self-checking bench for riscv_testutil_bus_arb (MaxOutstanding = 2).
// A queue-based reference model predicts every DUT output each cycle; directed
// scenarios also check key outputs against hand-derived constants.
module tb_riscv_testutil_bus_arb;
   localparam int MAX_OUT = 2;
   localparam int CORE = 0;
   localparam int TU = 1;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        core_req, core_we;
   logic [3:0]  core_be;
   logic [31:0] core_addr, core_wdata;
   logic        core_gnt, core_rvalid, core_err;
   logic [31:0] core_rdata;
   logic        tu_req;
   logic [31:0] tu_addr;
   logic        tu_gnt, tu_rvalid;
   logic [31:0] tu_rdata;
   logic        mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_gnt, mem_rvalid, mem_err;
   logic [31:0] mem_rdata;
   logic        unexp;

   int errors = 0;
   int checks = 0;

   // reference model state
   int          own_m[$];
   bit          sticky_m;
   int          last_m;
   logic [139:0] exp_vec;
   bit          exp_accept, exp_pop;
   int          exp_win;

   always #5 clk_i = ~clk_i;

   riscv_testutil_bus_arb #(.MaxOutstanding(MAX_OUT)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .core_req_i(core_req), .core_we_i(core_we), .core_be_i(core_be),
      .core_addr_i(core_addr), .core_wdata_i(core_wdata),
      .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid),
      .core_rdata_o(core_rdata), .core_err_o(core_err),
      .tu_req_i(tu_req), .tu_addr_i(tu_addr), .tu_gnt_o(tu_gnt),
      .tu_rvalid_o(tu_rvalid), .tu_rdata_o(tu_rdata),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
      .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
      .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
      .unexpected_rvalid_o(unexp)
   );

   function automatic logic [139:0] dut_vec();
      return {mem_req, mem_we, mem_be, mem_addr, mem_wdata, core_gnt, tu_gnt,
              core_rvalid, tu_rvalid, core_err, unexp, core_rdata, tu_rdata};
   endfunction

   task automatic model_reset();
      own_m.delete();
      sticky_m = 1'b0;
      last_m   = TU;
   endtask

   // Predict all outputs from the arbitration and routing rules
   task automatic model_eval();
      bit full, any, m_req, crv, trv;
      logic m_we;
      logic [3:0] m_be;
      logic [31:0] m_addr, m_wdata;
      full = (own_m.size() >= MAX_OUT);
      any  = core_req || tu_req;
      if (core_req && tu_req) begin
`ifdef RISCV_TESTUTIL_ARB_RR_EN
         exp_win = (last_m == TU) ? CORE : TU;
`else
         exp_win = TU;
`endif
      end else begin
         exp_win = tu_req ? TU : CORE;
      end
      m_req = any && !full;
      if (!any) begin
         m_we = 1'b0; m_be = 4'h0; m_addr = 32'h0; m_wdata = 32'h0;
      end else if (exp_win == TU) begin
         m_we = 1'b0; m_be = 4'hf; m_addr = tu_addr; m_wdata = 32'h0;
      end else begin
         m_we = core_we; m_be = core_be; m_addr = core_addr; m_wdata = core_wdata;
      end
      exp_accept = m_req && mem_gnt;
      exp_pop    = mem_rvalid && (own_m.size() > 0);
      crv = exp_pop && (own_m[0] == CORE);
      trv = exp_pop && (own_m[0] == TU);
      exp_vec = {m_req, m_we, m_be, m_addr, m_wdata,
                 exp_accept && (exp_win == CORE), exp_accept && (exp_win == TU),
                 crv, trv, mem_err && crv, sticky_m, mem_rdata, mem_rdata};
   endtask

   task automatic model_commit();
      if (mem_rvalid && own_m.size() == 0) sticky_m = 1'b1;
      if (exp_pop) void'(own_m.pop_front());
      if (exp_accept) begin
         own_m.push_back(exp_win);
         last_m = exp_win;
      end
   endtask

   // Apply one cycle of inputs away from the clock edge and predict outputs
   task automatic present(input bit cr, input bit cwe, input logic [3:0] cbe,
                          input logic [31:0] caddr, input logic [31:0] cwd,
                          input bit tr, input logic [31:0] taddr, input bit gnt,
                          input bit rv, input logic [31:0] rdata, input bit err);
      @(negedge clk_i);
      core_req = cr; core_we = cwe; core_be = cbe; core_addr = caddr; core_wdata = cwd;
      tu_req = tr; tu_addr = taddr;
      mem_gnt = gnt; mem_rvalid = rv; mem_rdata = rdata; mem_err = err;
      #1;
      model_eval();
   endtask

   task automatic advance();
      @(posedge clk_i);
      model_commit();
   endtask

   task automatic drive_idle();
      core_req = 1'b0; core_we = 1'b0; core_be = 4'h0; core_addr = 32'h0; core_wdata = 32'h0;
      tu_req = 1'b0; tu_addr = 32'h0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      drive_idle();
      rst_ni = 1'b0;
      model_reset();
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic test_reset();
      drive_idle();
      rst_ni = 1'b0;
      model_reset();
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      #1;
      model_eval();
      checks++;
      if (dut_vec() !== exp_vec) begin
         errors++; $display("FAIL reset_outputs: got %h want %h", dut_vec(), exp_vec);
      end
      checks++;
      if ({mem_req, core_gnt, tu_gnt, core_rvalid, tu_rvalid, unexp} !== 6'b0) begin
         errors++; $display("FAIL reset_zero: got %b want 000000",
                            {mem_req, core_gnt, tu_gnt, core_rvalid, tu_rvalid, unexp});
      end
      rst_ni = 1'b1;
   endtask

   task automatic test_core_write();
      present(1'b1, 1'b1, 4'hf, 32'h100, 32'h12345678, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec) begin
         errors++; $display("FAIL core_write_req: got %h want %h", dut_vec(), exp_vec);
      end
      checks++;
      if ({core_gnt, tu_gnt, mem_we, mem_req, mem_addr, mem_wdata} !== {4'b1011, 32'h100, 32'h12345678}) begin
         errors++; $display("FAIL core_write_fields: got %b %h %h want 1011 00000100 12345678",
                            {core_gnt, tu_gnt, mem_we, mem_req}, mem_addr, mem_wdata);
      end
      advance();
      present(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA5A50001, 1'b0);
      checks++;
      if ({core_rvalid, tu_rvalid} !== 2'b10) begin
         errors++; $display("FAIL core_write_rvalid: got %b want 10", {core_rvalid, tu_rvalid});
      end
      checks++;
      if (dut_vec() !== exp_vec) begin
         errors++; $display("FAIL core_write_rsp: got %h want %h", dut_vec(), exp_vec);
      end
      advance();
   endtask

   task automatic test_tu_read();
      present(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0);
      checks++;
      if ({tu_gnt, core_gnt, mem_we, mem_be, mem_addr} !== {3'b100, 4'hf, 32'h200}) begin
         errors++; $display("FAIL tu_read_req: got %b %h %h want 100 f 00000200",
                            {tu_gnt, core_gnt, mem_we}, mem_be, mem_addr);
      end
      advance();
      for (int i = 0; i < 2; i++) begin
         present(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
         checks++;
         if (dut_vec() !== exp_vec) begin
            errors++; $display("FAIL tu_read_wait%0d: got %h want %h", i, dut_vec(), exp_vec);
         end
         advance();
      end
      // error on a tu response has nowhere to go and is dropped
      present(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
      checks++;
      if ({tu_rvalid, core_rvalid, core_err, tu_rdata} !== {3'b100, 32'hDEADBEEF}) begin
         errors++; $display("FAIL tu_read_rsp: got %b %h want 100 deadbeef",
                            {tu_rvalid, core_rvalid, core_err}, tu_rdata);
      end
      advance();
   endtask

   task automatic test_contention();
      logic [1:0] want;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         present(1'b1, 1'b1, 4'h3, $urandom, $urandom, 1'b1, $urandom, 1'b1,
                 (i > 0), $urandom, 1'b0);
`ifdef RISCV_TESTUTIL_ARB_RR_EN
         want = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
         want = 2'b01;
`endif
         checks++;
         if ({core_gnt, tu_gnt} !== want) begin
            errors++; $display("FAIL contention_gnt%0d: got %b want %b", i, {core_gnt, tu_gnt}, want);
         end
         checks++;
         if (dut_vec() !== exp_vec) begin
            errors++; $display("FAIL contention_vec%0d: got %h want %h", i, dut_vec(), exp_vec);
         end
         advance();
      end
      present(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, $urandom, 1'b0);
      advance();
   endtask

   task automatic test_back_to_back();
      int sel[8] = '{2, 1, 2, 2, 2, 2, 0, 0};
      bit rv[8]  = '{0, 0, 0, 0, 1, 0, 1, 1};
      bit emr[8] = '{1, 1, 0, 0, 0, 1, 0, 0};
      logic [1:0] ert[8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         present(sel[i] == 1, 1'b0, 4'hf, 32'h300 + i, 32'h0, sel[i] == 2, 32'h400 + i,
                 1'b1, rv[i], $urandom, 1'b0);
         checks++;
         if (mem_req !== emr[i]) begin
            errors++; $display("FAIL b2b_memreq%0d: got %b want %b", i, mem_req, emr[i]);
         end
         checks++;
         if ({core_rvalid, tu_rvalid} !== ert[i]) begin
            errors++; $display("FAIL b2b_route%0d: got %b want %b", i, {core_rvalid, tu_rvalid}, ert[i]);
         end
         checks++;
         if (dut_vec() !== exp_vec) begin
            errors++; $display("FAIL b2b_vec%0d: got %h want %h", i, dut_vec(), exp_vec);
         end
         advance();
      end
   endtask

   task automatic test_unexpected();
      do_reset();
      present(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h5555AAAA, 1'b1);
      checks++;
      if ({core_rvalid, tu_rvalid, core_err} !== 3'b000) begin
         errors++; $display("FAIL unexp_fwd: got %b want 000", {core_rvalid, tu_rvalid, core_err});
      end
      advance();
      for (int i = 0; i < 3; i++) begin
         present(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
         checks++;
         if (unexp !== 1'b1) begin
            errors++; $display("FAIL unexp_sticky%0d: got %b want 1", i, unexp);
         end
         advance();
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 2; i++) begin
         present(1'b1, 1'b0, 4'hf, 32'h500 + i, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
         advance();
      end
      @(negedge clk_i);
      drive_idle();
      rst_ni = 1'b0;
      model_reset();
      #1;
      checks++;
      if (unexp !== 1'b0) begin
         errors++; $display("FAIL midrst_clear: got %b want 0", unexp);
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      present(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h11112222, 1'b0);
      checks++;
      if ({core_rvalid, tu_rvalid} !== 2'b00) begin
         errors++; $display("FAIL midrst_stale: got %b want 00", {core_rvalid, tu_rvalid});
      end
      advance();
      present(1'b1, 1'b0, 4'hf, 32'h600, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      checks++;
      if ({core_gnt, mem_req, unexp} !== 3'b111) begin
         errors++; $display("FAIL midrst_gnt: got %b want 111", {core_gnt, mem_req, unexp});
      end
      advance();
      present(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h33334444, 1'b1);
      checks++;
      if ({core_rvalid, core_err} !== 2'b11) begin
         errors++; $display("FAIL midrst_rsp: got %b want 11", {core_rvalid, core_err});
      end
      advance();
   endtask

   task automatic test_random();
      bit rv;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         rv = (own_m.size() > 0) ? ($urandom_range(0, 2) != 0) : 1'b0;
         present($urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom, $urandom,
                 $urandom_range(0, 1), $urandom, $urandom_range(0, 3) != 0,
                 rv, $urandom, $urandom_range(0, 1));
         checks++;
         if (dut_vec() !== exp_vec) begin
            errors++; $display("FAIL random%0d: got %h want %h", i, dut_vec(), exp_vec);
         end
         advance();
      end
   endtask

   initial begin
      rst_ni = 1'b0;
      drive_idle();
      model_reset();
      test_reset();
      test_core_write();
      test_tu_read();
      test_contention();
      test_back_to_back();
      test_unexpected();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
